sram_wr_sched: RTL and testbench
================================

Name: sram_wr_sched

Overview:
- Write-port scheduler and initialiser for the 3-write-port register-file SRAM (4R3W).
- Takes up to 4 write requesters over valid/ready handshakes and maps the winners onto the 3 physical write ports each cycle, using round-robin priority and same-address conflict suppression.
- Owns a clear-engine FSM that zeroes every SRAM entry on request, because the SRAM itself has no reset clear.
- Sits between the lane writeback stages and the SRAM write ports.

Parameters:
- SRAM_DEPTH, 32, number of SRAM entries.
- SRAM_INDEX, 5, address width; SRAM_DEPTH <= 2^SRAM_INDEX.
- SRAM_WIDTH, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- req_valid_i  in  4  per-requester write valid.
- req_addr_i  in  4*SRAM_INDEX  requester r address at [r*SRAM_INDEX +: SRAM_INDEX].
- req_data_i  in  4*SRAM_WIDTH  requester r data at [r*SRAM_WIDTH +: SRAM_WIDTH].
- req_ready_o  out  4  per-requester grant; combinational.
- init_i  in  1  start-clear request, level-sampled in IDLE.
- init_busy_o  out  1  high while the FSM is in CLEAR.
- init_done_o  out  1  one-cycle pulse when the last clear write is driven.
- addr0wr_o / addr1wr_o / addr2wr_o  out  SRAM_INDEX each  SRAM write addresses.
- we0_o / we1_o / we2_o  out  1 each  SRAM write enables.
- data0wr_o / data1wr_o / data2wr_o  out  SRAM_WIDTH each  SRAM write data.

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, clear counter=0.
  - All we*_o, addr*_o, data*_o = 0.
  - init_done_o=0, init_busy_o=0.
  - req_ready_o=0 while reset is high.
- Handshake:
  - A transfer happens when req_valid_i[r] & req_ready_o[r].
  - req_ready_o may depend on the current cycle's valids and addresses.
  - Requesters must hold addr/data stable while valid and not ready.
- Arbitration, IDLE only:
  - Scan order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Requester r is granted if all hold: it is valid, fewer than 3 requesters are already granted this cycle, and its address differs from every address already granted this cycle.
  - The k-th grant in scan order (k=0..2) goes to write port k.
- Pipeline:
  - Grants are registered; port k drives we/addr/data exactly 1 cycle after the handshake.
  - Unused ports have we=0; addr/data hold their previous values.
  - Write latency is request accepted in cycle N, SRAM write visible at edge N+2.
- Pointer:
  - If any grant occurs, ptr <= (last granted index in scan order + 1) mod 4.
  - If no grant occurs, ptr is unchanged.
- Same-address guarantee: the 3 ports never carry we=1 with equal addresses in the same cycle.
- FSM, states IDLE and CLEAR:
  - IDLE and init_i=1: go to CLEAR with cnt=0. req_ready_o=0 that cycle, so init beats pending requests.
  - CLEAR cycle with counter cnt: register writes of 0 to addresses cnt, cnt+1, cnt+2 on ports 0/1/2. Any port whose address is >= SRAM_DEPTH has we=0.
  - Then cnt += 3.
  - When cnt+3 >= SRAM_DEPTH, this is the final CLEAR cycle: the next state is IDLE and init_done_o is registered high, so it coincides with the final clear writes on the outputs.
  - For SRAM_DEPTH=32, CLEAR lasts 11 cycles (ceil(32/3)).
- In CLEAR:
  - req_ready_o=0, init_i is ignored, ptr is frozen.
  - init_busy_o = (state==CLEAR), decoded from the state register.
- Reset mid-CLEAR: next cycle is IDLE with all we=0, no done pulse, and a partially cleared SRAM. Software must re-issue init.
- ptr wraps from 3 to 0. cnt width is SRAM_INDEX+2 to avoid overflow.

Test Plan:
- Single write: ptr=0, req1 valid addr=7 data=0xA5A5A5A5 -> ready=0010 same cycle. Next cycle we0=1, addr0=7, data0=0xA5A5A5A5, we1=we2=0. ptr becomes 2.
- Oversubscription: all 4 valid, addrs 1,2,3,4, ptr=0 -> ready=0111. Ports 0/1/2 get addrs 1/2/3, ptr=3. Next cycle req3 ready alone, goes on port 0, ptr=0.
- Address conflict: ptr=0, addrs req0=1, req1=5, req2=5, req3=9 -> ready=1011. Ports get 1/5/9, ptr=0. Next cycle req2 (addr 5) is granted.
- Clear: init_i pulse in IDLE with requests pending -> ready=0 and init_busy_o high for 11 cycles. Addresses 0..31 are each written with 0 exactly once; the final cycle has we0=we1=1 (30, 31) and we2=0. init_done_o pulses once with that write. A read-back of all 32 entries returns 0.
- Init during CLEAR: pulse init_i at cycle 5 of CLEAR -> no restart, total still 11 cycles, one done pulse.
- Reset mid-CLEAR: assert reset at CLEAR cycle 4 -> all we=0 the next cycle, state IDLE, no init_done_o. Requests are granted again after reset deasserts, starting from ptr=0.

Source files
------------

// File: rtl/sram_wr_sched.sv
// Write-port scheduler for the 4R3W register-file SRAM: round-robin maps up to four
// requesters onto three registered write ports, and owns a clear engine that zeroes the array.
module sram_wr_sched #(
    parameter int SRAM_DEPTH = 32,
    parameter int SRAM_INDEX = 5,
    parameter int SRAM_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              req_valid_i,
    input  logic [4*SRAM_INDEX-1:0] req_addr_i,
    input  logic [4*SRAM_WIDTH-1:0] req_data_i,
    output logic [3:0]              req_ready_o,
    input  logic                    init_i,
    output logic                    init_busy_o,
    output logic                    init_done_o,
    output logic [SRAM_INDEX-1:0]   addr0wr_o,
    output logic [SRAM_INDEX-1:0]   addr1wr_o,
    output logic [SRAM_INDEX-1:0]   addr2wr_o,
    output logic                    we0_o,
    output logic                    we1_o,
    output logic                    we2_o,
    output logic [SRAM_WIDTH-1:0]   data0wr_o,
    output logic [SRAM_WIDTH-1:0]   data1wr_o,
    output logic [SRAM_WIDTH-1:0]   data2wr_o
);

    localparam int CW = SRAM_INDEX + 2;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state, state_next;
    logic [1:0]            ptr, ptr_next;
    logic [CW-1:0]         cnt, cnt_next;

    logic [SRAM_INDEX-1:0] req_addr [4];
    logic [SRAM_WIDTH-1:0] req_data [4];

    logic                  arb_en;
    logic [3:0]            grant;
    logic [2:0]            port_vld;
    logic [1:0]            port_sel  [3];
    logic [SRAM_INDEX-1:0] port_addr [3];
    logic [1:0]            last_idx;

    logic [2:0]            we_q, we_next;
    logic [SRAM_INDEX-1:0] addr_q [3];
    logic [SRAM_INDEX-1:0] addr_next [3];
    logic [SRAM_WIDTH-1:0] data_q [3];
    logic [SRAM_WIDTH-1:0] data_next [3];
    logic                  done_q, done_next;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            req_addr[r] = req_addr_i[r*SRAM_INDEX +: SRAM_INDEX];
            req_data[r] = req_data_i[r*SRAM_WIDTH +: SRAM_WIDTH];
        end
    end

    // Grants are withheld while clearing, under reset, and in the cycle init is taken.
    assign arb_en = (state == IDLE) && !init_i && !reset;

    // Round-robin scan from ptr; the k-th winner lands on port k, duplicate addresses wait.
    always_comb begin
        logic [1:0] r;
        logic       hit;
        logic [1:0] n_grant;
        grant    = '0;
        port_vld = '0;
        last_idx = ptr;
        n_grant  = '0;
        r        = '0;
        hit      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            port_sel[k]  = '0;
            port_addr[k] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            r   = ptr + 2'(i);
            hit = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (port_vld[k] && port_addr[k] == req_addr[r]) begin
                    hit = 1'b1;
                end
            end
            if (arb_en && req_valid_i[r] && n_grant < 2'd3 && !hit) begin
                grant[r]           = 1'b1;
                port_vld[n_grant]  = 1'b1;
                port_sel[n_grant]  = r;
                port_addr[n_grant] = req_addr[r];
                last_idx           = r;
                n_grant            = n_grant + 2'd1;
            end
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        logic [CW-1:0] clr_addr;
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        we_next    = '0;
        done_next  = 1'b0;
        clr_addr   = '0;
        for (int k = 0; k < 3; k++) begin
            addr_next[k] = addr_q[k];
            data_next[k] = data_q[k];
        end
        case (state)
            IDLE: begin
                if (init_i) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        if (port_vld[k]) begin
                            we_next[k]   = 1'b1;
                            addr_next[k] = port_addr[k];
                            data_next[k] = req_data[port_sel[k]];
                        end
                    end
                    if (|grant) begin
                        ptr_next = last_idx + 2'd1;
                    end
                end
            end
            CLEAR: begin
                // Three consecutive entries per cycle; entries past the array end are masked.
                for (int k = 0; k < 3; k++) begin
                    clr_addr = cnt + CW'(k);
                    if (clr_addr < CW'(SRAM_DEPTH)) begin
                        we_next[k]   = 1'b1;
                        addr_next[k] = clr_addr[SRAM_INDEX-1:0];
                        data_next[k] = '0;
                    end
                end
                cnt_next = cnt + CW'(3);
                if (cnt + CW'(3) >= CW'(SRAM_DEPTH)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            we_q    <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            cnt     <= cnt_next;
            we_q    <= we_next;
            done_q  <= done_next;
            for (int k = 0; k < 3; k++) begin
                addr_q[k] <= addr_next[k];
                data_q[k] <= data_next[k];
            end
        end
    end

    assign init_busy_o = (state == CLEAR);
    assign init_done_o = done_q;
    assign we0_o       = we_q[0];
    assign we1_o       = we_q[1];
    assign we2_o       = we_q[2];
    assign addr0wr_o   = addr_q[0];
    assign addr1wr_o   = addr_q[1];
    assign addr2wr_o   = addr_q[2];
    assign data0wr_o   = data_q[0];
    assign data1wr_o   = data_q[1];
    assign data2wr_o   = data_q[2];

endmodule

// File: tb/tb_sram_wr_sched.sv
// Scoreboard bench for sram_wr_sched: directed requests and clear sequences push expected
// port writes into a queue that a negedge monitor pops whenever the DUT drives a write.
module tb_sram_wr_sched;

    localparam int DEPTH = 32;
    localparam int IDX   = 5;
    localparam int W     = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [4*IDX-1:0] req_addr;
    logic [4*W-1:0]   req_data;
    logic [3:0]       req_ready;
    logic             init;
    logic             busy, done;
    logic [IDX-1:0]   addr0, addr1, addr2;
    logic             we0, we1, we2;
    logic [W-1:0]     data0, data1, data2;

    typedef struct packed {
        logic [2:0]     we;
        logic [3*IDX-1:0] addr;
        logic [3*W-1:0] data;
        logic           done;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     e;
    int       checks = 0;
    int       failures = 0;
    int       done_count = 0;
    logic     fill_mem;
    logic [W-1:0] mem [DEPTH];

    sram_wr_sched #(.SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready),
        .init_i(init), .init_busy_o(busy), .init_done_o(done),
        .addr0wr_o(addr0), .addr1wr_o(addr1), .addr2wr_o(addr2),
        .we0_o(we0), .we1_o(we1), .we2_o(we2),
        .data0wr_o(data0), .data1wr_o(data1), .data2wr_o(data2)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM fed by the DUT write ports, pre-filled with non-zero junk.
    always @(posedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD0000 | W'(i);
        end else begin
            if (we0) mem[addr0] <= data0;
            if (we1) mem[addr1] <= data1;
            if (we2) mem[addr2] <= data2;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [2:0] we, input logic [IDX-1:0] a0, a1, a2,
                               input logic [W-1:0] d0, d1, d2, input logic dn);
        exp_t x;
        x.we   = we;
        x.addr = {a2, a1, a0};
        x.data = {d2, d1, d0};
        x.done = dn;
        exp_q.push_back(x);
    endtask

    // Starts at a negedge, drives one request vector, checks ready, ends at the next negedge.
    task automatic applyStimulus(input string name, input logic [3:0] v,
                                 input logic [IDX-1:0] a0, a1, a2, a3,
                                 input logic [W-1:0] d0, d1, d2, d3,
                                 input logic [3:0] exp_ready);
        req_valid = v;
        req_addr  = {a3, a2, a1, a0};
        req_data  = {d3, d2, d1, d0};
        #1;
        checkOutput(name, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
    endtask

    task automatic runClear(input int reinit_cycle);
        req_valid = 4'hF;
        req_addr  = {5'd3, 5'd2, 5'd1, 5'd0};
        init      = 1'b1;
        #1;
        checkOutput("init_ready", 32'(req_ready), 32'h0);
        checkOutput("init_busy_idle", 32'(busy), 32'h0);
        for (int j = 0; j < 11; j++) begin
            expectWrite({(3*j+2) < DEPTH, (3*j+1) < DEPTH, 1'b1},
                        5'(3*j), 5'(3*j+1), 5'(3*j+2), '0, '0, '0, j == 10);
        end
        @(negedge clk);
        for (int c = 1; c <= 11; c++) begin
            #1;
            checkOutput($sformatf("clear_busy_c%0d", c), 32'(busy), 32'h1);
            checkOutput($sformatf("clear_ready_c%0d", c), 32'(req_ready), 32'h0);
            init = (c == reinit_cycle);
            @(negedge clk);
        end
        init      = 1'b0;
        req_valid = 4'h0;
        #1;
        checkOutput("clear_busy_end", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: any write or done on the outputs must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we0 || we1 || we2 || done) begin
            if (done) done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got we=%b done=%b expected none",
                         {we2, we1, we0}, done);
            end else begin
                e = exp_q.pop_front();
                checkOutput("port_we", 32'({we2, we1, we0}), 32'(e.we));
                if (e.we[0]) begin
                    checkOutput("addr0", 32'(addr0), 32'(e.addr[0*IDX +: IDX]));
                    checkOutput("data0", data0, e.data[0*W +: W]);
                end
                if (e.we[1]) begin
                    checkOutput("addr1", 32'(addr1), 32'(e.addr[1*IDX +: IDX]));
                    checkOutput("data1", data1, e.data[1*W +: W]);
                end
                if (e.we[2]) begin
                    checkOutput("addr2", 32'(addr2), 32'(e.addr[2*IDX +: IDX]));
                    checkOutput("data2", data2, e.data[2*W +: W]);
                end
                checkOutput("done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset     = 1'b1;
        init      = 1'b0;
        req_valid = 4'h0;
        req_addr  = '0;
        req_data  = '0;
        fill_mem  = 1'b1;
        @(negedge clk);
        req_valid = 4'hF;
        req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_we", 32'({we2, we1, we0}), 32'h0);
        checkOutput("reset_addr0", 32'(addr0), 32'h0);
        checkOutput("reset_data2", data2, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        fill_mem  = 1'b0;
        req_valid = 4'h0;

        // Single write from req1; ptr moves to 2.
        expectWrite(3'b001, 5'd7, 5'd0, 5'd0, 32'hA5A5A5A5, '0, '0, 1'b0);
        applyStimulus("single", 4'b0010, 5'd0, 5'd7, 5'd0, 5'd0,
                      '0, 32'hA5A5A5A5, '0, '0, 4'b0010);
        // From ptr=2 the scan is 2,3,0; ptr moves to 1.
        expectWrite(3'b111, 5'd12, 5'd13, 5'd10, 32'h12, 32'h13, 32'h10, 1'b0);
        applyStimulus("ptr2_scan", 4'b1111, 5'd10, 5'd11, 5'd12, 5'd13,
                      32'h10, 32'h11, 32'h12, 32'h13, 4'b1101);
        // Lone req3 from ptr=1; ptr wraps to 0.
        expectWrite(3'b001, 5'd15, 5'd0, 5'd0, 32'h15, '0, '0, 1'b0);
        applyStimulus("wrap", 4'b1000, 5'd0, 5'd0, 5'd0, 5'd15,
                      '0, '0, '0, 32'h15, 4'b1000);
        // Oversubscription: req3 waits, ptr=3, then it wins alone and ptr=0.
        expectWrite(3'b111, 5'd1, 5'd2, 5'd3, 32'h21, 32'h22, 32'h23, 1'b0);
        applyStimulus("oversub", 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4,
                      32'h21, 32'h22, 32'h23, 32'h24, 4'b0111);
        expectWrite(3'b001, 5'd4, 5'd0, 5'd0, 32'h24, '0, '0, 1'b0);
        applyStimulus("oversub_tail", 4'b1000, 5'd0, 5'd0, 5'd0, 5'd4,
                      '0, '0, '0, 32'h24, 4'b1000);
        // Address conflict: req2 shares addr 5 with req1 and is deferred.
        expectWrite(3'b111, 5'd1, 5'd5, 5'd9, 32'h31, 32'h32, 32'h34, 1'b0);
        applyStimulus("conflict", 4'b1111, 5'd1, 5'd5, 5'd5, 5'd9,
                      32'h31, 32'h32, 32'h33, 32'h34, 4'b1011);
        expectWrite(3'b001, 5'd5, 5'd0, 5'd0, 32'h33, '0, '0, 1'b0);
        applyStimulus("conflict_tail", 4'b0100, 5'd0, 5'd0, 5'd5, 5'd0,
                      '0, '0, 32'h33, '0, 4'b0100);
        applyStimulus("idle", 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, 4'b0000);

        // Full clear with requests pending, then read back every entry.
        runClear(0);
        checkOutput("done_count_1", 32'(done_count), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("readback_%0d", i), mem[i], 32'h0);
        end

        // init re-asserted during CLEAR cycle 5 must not restart the sweep.
        runClear(5);
        checkOutput("done_count_2", 32'(done_count), 32'd2);

        // Reset during CLEAR cycle 4: three clear writes escape, then nothing.
        req_valid = 4'h0;
        init      = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            expectWrite(3'b111, 5'(3*j), 5'(3*j+1), 5'(3*j+2), '0, '0, '0, 1'b0);
        end
        @(negedge clk);
        init = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checkOutput($sformatf("midrst_busy_c%0d", c), 32'(busy), 32'h1);
            if (c == 4) reset = 1'b1;
            @(negedge clk);
        end
        #1;
        checkOutput("midrst_we", 32'({we2, we1, we0}), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        // ptr restarts at 0 after reset.
        expectWrite(3'b111, 5'd20, 5'd21, 5'd22, 32'h40, 32'h41, 32'h42, 1'b0);
        applyStimulus("post_reset", 4'b1111, 5'd20, 5'd21, 5'd22, 5'd23,
                      32'h40, 32'h41, 32'h42, 32'h43, 4'b0111);
        req_valid = 4'h0;
        repeat (4) @(negedge clk);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("done_count_final", 32'(done_count), 32'd2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
